// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: boots from RESET_VECTOR, advances on accepted fetches,
// and applies jalr/jump/branch redirects with a one-cycle flush bubble or a sticky misalignment trap.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_src,
    input  logic        jump,
    input  logic        jalr,
    input  logic [31:0] branch_target,
    input  logic [31:0] jalr_target,
    input  logic        stall,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        flush,
    output logic        misaligned,
    output logic [15:0] redirect_cnt
);

    localparam int unsigned CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {BOOT, RUN, REDIRECT, TRAP} state_t;

    state_t      state;
    logic        redirect_req;
    logic [31:0] target;

    // jalr wins over jump/pc_src; its target drops bit 0 before the alignment check
    always_comb begin
        redirect_req = jalr | jump | pc_src;
        target       = jalr ? (jalr_target & 32'hFFFF_FFFE) : branch_target;
    end

    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= BOOT;
            pc           <= RESET_VECTOR;
            fetch_valid  <= 1'b0;
            flush        <= 1'b0;
            misaligned   <= 1'b0;
            redirect_cnt <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state       <= RUN;
                    fetch_valid <= 1'b1;
                end
                RUN, REDIRECT: begin
                    if (redirect_req) begin
                        fetch_valid <= 1'b0;
                        if (target[1:0] == 2'b00) begin
                            state <= REDIRECT;
                            pc    <= target;
                            flush <= 1'b1;
                            if (redirect_cnt != CNT_MAX)
                                redirect_cnt <= redirect_cnt + CNT_W'(1);
                        end else begin
                            state      <= TRAP;
                            flush      <= 1'b0;
                            misaligned <= 1'b1;
                        end
                    end else begin
                        state       <= RUN;
                        fetch_valid <= 1'b1;
                        flush       <= 1'b0;
                        // the bubble cycle after a redirect holds pc so the target is fetched once
                        if (state == RUN && imem_ready && !stall)
                            pc <= pc_plus4;
                    end
                end
                TRAP: begin
                    fetch_valid <= 1'b0;
                    flush       <= 1'b0;
                    misaligned  <= 1'b1;
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand-written corner
// sequences, and randomized traffic checked against a behavioural model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_src = 1'b0, jump = 1'b0, jalr = 1'b0;
    logic [31:0] branch_target = '0, jalr_target = '0;
    logic        stall = 1'b0, imem_ready = 1'b0;
    logic [31:0] pc, pc_plus4;
    logic        fetch_valid, flush, misaligned;
    logic [15:0] redirect_cnt;

    int n_chk = 0;
    int n_fail = 0;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .jump(jump), .jalr(jalr),
        .branch_target(branch_target), .jalr_target(jalr_target),
        .stall(stall), .imem_ready(imem_ready), .pc(pc), .pc_plus4(pc_plus4),
        .fetch_valid(fetch_valid), .flush(flush), .misaligned(misaligned),
        .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    // ctl = {jalr, jump, pc_src, stall, imem_ready}; flg = {fetch_valid, flush, misaligned}
    typedef struct {
        logic [4:0]  ctl;
        logic [31:0] bt;
        logic [31:0] jt;
        logic [31:0] epc;
        logic [2:0]  eflg;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vt[24];

    // behavioural model state
    logic [31:0] m_pc;
    logic        m_fv, m_fl, m_mis, m_boot;
    int          m_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [4:0] ctl, input logic [31:0] bt, input logic [31:0] jt);
        {jalr, jump, pc_src, stall, imem_ready} = ctl;
        branch_target = bt;
        jalr_target   = jt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_fv = 1'b0; m_fl = 1'b0; m_mis = 1'b0; m_boot = 1'b1; m_cnt = 0;
    endtask

    // one clock edge of the sequencer, described by its rules rather than its states
    task automatic model_step();
        logic [31:0] tgt;
        if (m_mis) return;
        if (m_boot) begin
            m_boot = 1'b0; m_fv = 1'b1;
            return;
        end
        if (jalr || jump || pc_src) begin
            tgt = jalr ? (jalr_target / 2) * 2 : branch_target;
            m_fv = 1'b0;
            if (tgt % 4 == 0) begin
                m_pc = tgt; m_fl = 1'b1;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                m_mis = 1'b1; m_fl = 1'b0;
            end
        end else if (m_fl) begin
            m_fl = 1'b0; m_fv = 1'b1;
        end else if (imem_ready && !stall) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check_model(input string nm);
        chk({nm, ".pc"}, pc, m_pc);
        chk({nm, ".pc_plus4"}, pc_plus4, m_pc + 32'd4);
        chk({nm, ".fetch_valid"}, 32'(fetch_valid), 32'(m_fv));
        chk({nm, ".flush"}, 32'(flush), 32'(m_fl));
        chk({nm, ".misaligned"}, 32'(misaligned), 32'(m_mis));
        chk({nm, ".redirect_cnt"}, 32'(redirect_cnt), 32'(m_cnt));
    endtask

    task automatic check_reset(input string nm);
        chk({nm, ".pc"}, pc, 32'h0);
        chk({nm, ".fetch_valid"}, 32'(fetch_valid), 32'd0);
        chk({nm, ".flush"}, 32'(flush), 32'd0);
        chk({nm, ".misaligned"}, 32'(misaligned), 32'd0);
        chk({nm, ".redirect_cnt"}, 32'(redirect_cnt), 32'd0);
    endtask

    // assert reset mid-cycle, check it took effect before any edge, release on a negedge
    task automatic async_reset(input string nm);
        #2 rst_n = 1'b0;
        #1 check_reset(nm);
        drive(5'b00001, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk({nm, ".boot_fv"}, 32'(fetch_valid), 32'd0);
    endtask

    initial begin
        vt[0]  = '{5'b00001, 32'h0,   32'h0,   32'h0000_0000, 3'b100, 16'd0};
        vt[1]  = '{5'b00001, 32'h0,   32'h0,   32'h0000_0004, 3'b100, 16'd0};
        vt[2]  = '{5'b00001, 32'h0,   32'h0,   32'h0000_0008, 3'b100, 16'd0};
        vt[3]  = '{5'b00001, 32'h0,   32'h0,   32'h0000_000C, 3'b100, 16'd0};
        vt[4]  = '{5'b00001, 32'h0,   32'h0,   32'h0000_0010, 3'b100, 16'd0};
        vt[5]  = '{5'b00011, 32'h0,   32'h0,   32'h0000_0010, 3'b100, 16'd0};
        vt[6]  = '{5'b00011, 32'h0,   32'h0,   32'h0000_0010, 3'b100, 16'd0};
        vt[7]  = '{5'b00011, 32'h0,   32'h0,   32'h0000_0010, 3'b100, 16'd0};
        vt[8]  = '{5'b00001, 32'h0,   32'h0,   32'h0000_0014, 3'b100, 16'd0};
        vt[9]  = '{5'b00000, 32'h0,   32'h0,   32'h0000_0014, 3'b100, 16'd0};
        vt[10] = '{5'b00000, 32'h0,   32'h0,   32'h0000_0014, 3'b100, 16'd0};
        vt[11] = '{5'b00000, 32'h0,   32'h0,   32'h0000_0014, 3'b100, 16'd0};
        vt[12] = '{5'b00001, 32'h0,   32'h0,   32'h0000_0018, 3'b100, 16'd0};
        vt[13] = '{5'b00001, 32'h0,   32'h0,   32'h0000_001C, 3'b100, 16'd0};
        vt[14] = '{5'b00001, 32'h0,   32'h0,   32'h0000_0020, 3'b100, 16'd0};
        vt[15] = '{5'b00111, 32'h100, 32'h0,   32'h0000_0100, 3'b010, 16'd1};
        vt[16] = '{5'b00001, 32'h0,   32'h0,   32'h0000_0100, 3'b100, 16'd1};
        vt[17] = '{5'b00001, 32'h0,   32'h0,   32'h0000_0104, 3'b100, 16'd1};
        vt[18] = '{5'b01101, 32'h40,  32'h0,   32'h0000_0040, 3'b010, 16'd2};
        vt[19] = '{5'b11001, 32'h80,  32'h201, 32'h0000_0200, 3'b010, 16'd3};
        vt[20] = '{5'b00001, 32'h0,   32'h0,   32'h0000_0200, 3'b100, 16'd3};
        vt[21] = '{5'b00001, 32'h0,   32'h0,   32'h0000_0204, 3'b100, 16'd3};
        vt[22] = '{5'b10101, 32'h40,  32'h203, 32'h0000_0204, 3'b001, 16'd3};
        vt[23] = '{5'b00101, 32'h100, 32'h0,   32'h0000_0204, 3'b001, 16'd3};

        // power-on reset, then exactly one BOOT cycle
        #12 check_reset("por");
        drive(5'b00001, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("boot.fv", 32'(fetch_valid), 32'd0);
        chk("boot.pc", pc, 32'h0);

        for (int i = 0; i < 24; i++) begin
            drive(vt[i].ctl, vt[i].bt, vt[i].jt);
            tick();
            chk($sformatf("vec%0d.pc", i), pc, vt[i].epc);
            chk($sformatf("vec%0d.pc_plus4", i), pc_plus4, vt[i].epc + 32'd4);
            chk($sformatf("vec%0d.flags", i), 32'({fetch_valid, flush, misaligned}), 32'(vt[i].eflg));
            chk($sformatf("vec%0d.cnt", i), 32'(redirect_cnt), 32'(vt[i].ecnt));
        end

        // asynchronous reset out of TRAP
        async_reset("rst_trap");
        tick();
        chk("rst_trap.run_fv", 32'(fetch_valid), 32'd1);

        // pc wrap at the top of the address space
        drive(5'b01001, 32'hFFFF_FFFC, 32'h0);
        tick();
        chk("wrap.pc", pc, 32'hFFFF_FFFC);
        chk("wrap.pc_plus4", pc_plus4, 32'h0);
        drive(5'b00001, 32'h0, 32'h0);
        tick();
        chk("wrap.hold", pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap.pc0", pc, 32'h0);

        // reset in the middle of a redirect bubble leaves no flush behind
        drive(5'b00101, 32'h300, 32'h0);
        tick();
        chk("rst_redir.flush_pre", 32'(flush), 32'd1);
        async_reset("rst_redir");
        tick();

        // saturate redirect_cnt with back-to-back redirects
        drive(5'b00101, 32'h100, 32'h0);
        repeat (65535) @(posedge clk);
        #1 chk("sat.cnt_max", 32'(redirect_cnt), 32'h0000_FFFF);
        tick();
        chk("sat.cnt_hold", 32'(redirect_cnt), 32'h0000_FFFF);
        chk("sat.flush", 32'(flush), 32'd1);
        chk("sat.pc", pc, 32'h100);

        // randomized traffic against the model
        async_reset("rnd_rst");
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            if (m_mis && $urandom_range(3) == 0) begin
                async_reset("rnd_trap_rst");
                model_reset();
            end
            jalr  = ($urandom_range(15) == 0);
            jump  = ($urandom_range(11) == 0);
            pc_src = ($urandom_range(7) == 0);
            stall = ($urandom_range(3) == 0);
            imem_ready = ($urandom_range(3) != 0);
            branch_target = $urandom & ~32'h3;
            jalr_target   = $urandom & ~32'h2;
            if ($urandom_range(15) == 0) branch_target = $urandom;
            if ($urandom_range(15) == 0) jalr_target = $urandom;
            model_step();
            tick();
            check_model($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_VECTOR, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have port pc_src, input, 1, taken-branch strobe from the branch control unit.
REQ-005 The block SHALL have port jump, input, 1, JAL redirect strobe.
REQ-006 The block SHALL have port jalr, input, 1, JALR redirect strobe.
REQ-007 The block SHALL have port branch_target, input, 32, target for pc_src and jump.
REQ-008 The block SHALL have port jalr_target, input, 32, raw rs1+imm sum for jalr.
REQ-009 The block SHALL have port stall, input, 1, downstream hazard hold.
REQ-010 The block SHALL have port imem_ready, input, 1, instruction memory accepted the current pc.
REQ-011 The block SHALL have port pc, output, 32, current fetch address.
REQ-012 The block SHALL have port pc_plus4, output, 32, combinational pc+4, modulo 2^32.
REQ-013 The block SHALL have port fetch_valid, output, 1, pc is a live fetch request.
REQ-014 The block SHALL have port flush, output, 1, one-cycle pulse telling younger stages to discard.
REQ-015 The block SHALL have port misaligned, output, 1, sticky instruction-address-misaligned fault.
REQ-016 The block SHALL have port redirect_cnt, output, 16, count of accepted redirects, saturating.

Function
REQ-017 The block SHALL implement states BOOT, RUN, REDIRECT, TRAP.
REQ-018 BOOT: fetch_valid=0; the next edge SHALL go unconditionally to RUN with pc unchanged.
REQ-019 RUN: fetch_valid=1; a redirect request (jalr|jump|pc_src) SHALL take priority over stall and imem_ready.
REQ-020 Redirect priority SHALL be jalr > jump > pc_src; the target is jalr_target with bit0 cleared for jalr, otherwise branch_target.
REQ-021 On an accepted redirect with target[1:0]==2'b00: pc<=target, flush=1 next cycle, state->REDIRECT, redirect_cnt+1 (holds at 16'hFFFF).
REQ-022 On a redirect with target[1:0]!=2'b00: state->TRAP, misaligned<=1, pc unchanged, no flush, redirect_cnt unchanged.
REQ-023 RUN with no redirect: pc<=pc+4 (wraps 32'hFFFF_FFFC->0) only when imem_ready=1 and stall=0; otherwise pc holds.
REQ-024 REDIRECT: fetch_valid=0 (one bubble), flush=1; the next edge SHALL go to RUN, unless a new redirect is present, which is handled as in RUN (state stays REDIRECT).
REQ-025 flush SHALL be high only in REDIRECT cycles; never in BOOT, RUN or TRAP.
REQ-026 TRAP: fetch_valid=0, flush=0, misaligned=1; all inputs ignored until reset.
REQ-027 Redirect inputs SHALL be sampled only in RUN and REDIRECT.

Reset
REQ-028 rst_n=0 SHALL immediately force pc=RESET_VECTOR, state=BOOT, fetch_valid=0, flush=0, misaligned=0, redirect_cnt=0, regardless of clk.
REQ-029 Reset asserted mid-REDIRECT or mid-TRAP SHALL abandon the operation with no residual flush or fault.
REQ-030 Release of rst_n SHALL yield exactly one BOOT cycle before the first fetch_valid=1.

Verification
REQ-031 Reset release, imem_ready=1, stall=0 -> pc 0x0 (BOOT, fetch_valid=0), 0x0, 0x4, 0x8 with fetch_valid=1.
REQ-032 pc=0x10, stall=1 for 3 cycles, imem_ready=1 -> pc holds 0x10, then 0x14; same for imem_ready=0 with stall=0.
REQ-033 pc=0x20, pc_src=1, branch_target=0x100, stall=1 -> next pc=0x100, flush=1 and fetch_valid=0 for one cycle, redirect_cnt=1, then pc 0x100 with fetch_valid=1.
REQ-034 jalr=1, jalr_target=0x203, pc_src=1, branch_target=0x40 -> pc=0x202? No: bit0 cleared gives 0x202, [1:0]!=0 -> TRAP, misaligned=1, pc unchanged; jalr_target=0x201 -> pc=0x200, no fault.
REQ-035 pc=0xFFFF_FFFC, advance -> pc=0x0; redirect_cnt preloaded by 65535 redirects -> stays 0xFFFF after another.
REQ-036 rst_n pulsed low asynchronously in TRAP -> misaligned=0, pc=RESET_VECTOR, fetch_valid=0 before next clk edge.
